// File: rtl/seq_pd_pkg.sv
// Shared types and sizing helpers for the programmable serial pattern detector.
package seq_pd_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ARMED,
        ST_ERR
    } state_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pd_shift_cmp.sv
// History shift register plus length-masked comparison of the newest bits against the pattern.
module pd_shift_cmp #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               bit_in,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               eq
);

    logic [MAX_LEN-2:0] history_q;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    // The incoming bit completes the window, so a match is seen on the accepting edge itself.
    assign window = {history_q, bit_in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign eq = (((window ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history_q <= '0;
        end else if (clear) begin
            history_q <= '0;
        end else if (shift_en) begin
            history_q <= window[MAX_LEN-2:0];
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector: FSM, fill counter, config registers and match counter.
module seq_pattern_detector
    import seq_pd_pkg::*;
#(
    parameter int                 MAX_LEN         = 16,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'('h000B),
    parameter int                 DEFAULT_LEN     = 4,
    parameter bit                 DEFAULT_OVERLAP = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pattern,
    input  logic                         bit_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]    cfg_len,
    input  logic                         cfg_overlap,
    output logic                         pattern_found,
    output logic [CNT_W-1:0]             match_count,
    output logic                         count_sat,
    output logic                         cfg_err
);

    localparam int                 LEN_W   = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0]   ONE_LEN = LEN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               err_q, err_d;
    logic               found_q, found_d;

    logic accept;
    logic eq;
    logic match;
    logic restart;
    logic len_ok;

    assign accept  = bit_valid && !cfg_load && (state_q != ST_ERR);
    assign match   = accept && (state_q == ST_ARMED) && eq;
    assign restart = match && !ovl_q;
    assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    pd_shift_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift_cmp (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .clear    (cfg_load || restart),
        .bit_in   (pattern),
        .len      (len_q),
        .pattern  (pat_q),
        .eq       (eq)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        err_d   = err_q;
        found_d = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            fill_d = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
            if (!len_ok) begin
                err_d   = 1'b1;
                state_d = ST_ERR;
            end else begin
                err_d   = 1'b0;
                state_d = (cfg_len == ONE_LEN) ? ST_ARMED : ST_FILL;
            end
        end else if (accept) begin
            case (state_q)
                ST_FILL: begin
                    fill_d = fill_q + ONE_LEN;
                    if (fill_d == len_q - ONE_LEN) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (match) begin
                        found_d = 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        sat_d = sat_q || (cnt_d == CNT_MAX);
                        // Non-overlap: the completing bit is not reused by the next match.
                        if (!ovl_q) begin
                            fill_d  = '0;
                            state_d = (len_q == ONE_LEN) ? ST_ARMED : ST_FILL;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= (DEFAULT_LEN == 1) ? ST_ARMED : ST_FILL;
            fill_q  <= '0;
            pat_q   <= DEFAULT_PATTERN;
            len_q   <= LEN_W'(DEFAULT_LEN);
            ovl_q   <= DEFAULT_OVERLAP;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            found_q <= found_d;
        end
    end

    assign pattern_found = found_q;
    assign match_count   = cnt_q;
    assign count_sat     = sat_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scenario bench for seq_pattern_detector: default and narrow-counter instances share one stimulus stream.
module tb_seq_pattern_detector;

    logic        clk;
    logic        rst;
    logic        pattern;
    logic        bit_valid;
    logic        cfg_load;
    logic [15:0] cfg_pattern;
    logic [4:0]  cfg_len;
    logic        cfg_overlap;

    logic        found, sat, err;
    logic [7:0]  count;
    logic        found2, sat2, err2;
    logic [1:0]  count2;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    seq_pattern_detector dut (
        .clk(clk), .rst(rst), .pattern(pattern), .bit_valid(bit_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .pattern_found(found), .match_count(count),
        .count_sat(sat), .cfg_err(err)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .pattern(pattern), .bit_valid(bit_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .pattern_found(found2), .match_count(count2),
        .count_sat(sat2), .cfg_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; the expected pulse is queued, then popped once the DUT has registered it.
    task automatic step(input logic v, input logic b, input bit exp_found, input string name);
        bit e;
        bit_valid = v;
        pattern   = b;
        cfg_load  = 1'b0;
        exp_q.push_back(exp_found);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (found !== e) begin
            errors++;
            $display("FAIL %s: pattern_found=%b expected %b", name, found, e);
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] exps, input int n, input string name);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], exps[i], name);
        end
    endtask

    // A bit is also offered alongside the load so that its required drop is exercised.
    task automatic load(input logic [15:0] p, input logic [4:0] l, input logic ovl);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        bit_valid   = 1'b1;
        pattern     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (found !== 1'b0) begin
            errors++;
            $display("FAIL load_found: pattern_found=%b expected 0", found);
        end
        @(negedge clk);
        cfg_load  = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic check_cnt(input logic [7:0] exp_cnt, input logic exp_sat, input string name);
        checks++;
        if (count !== exp_cnt || sat !== exp_sat) begin
            errors++;
            $display("FAIL %s: count=%0d sat=%b expected count=%0d sat=%b", name, count, sat, exp_cnt, exp_sat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pattern = 1'b0; bit_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (found !== 1'b0 || count !== 8'd0 || sat !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: found=%b count=%0d sat=%b err=%b expected all 0", found, count, sat, err);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overlap();
        stream(16'b1011011, 16'b0001001, 7, "overlap");
        check_cnt(8'd2, 1'b0, "overlap_count");
    endtask

    task automatic test_nonoverlap();
        load(16'h000B, 5'd4, 1'b0);
        stream(16'b1011011, 16'b0001000, 7, "nonoverlap");
        check_cnt(8'd1, 1'b0, "nonoverlap_count");
    endtask

    task automatic test_gaps();
        load(16'h000B, 5'd4, 1'b1);
        step(1'b1, 1'b1, 1'b0, "gaps");
        step(1'b0, 1'b0, 1'b0, "gaps_idle");
        step(1'b0, 1'b1, 1'b0, "gaps_idle");
        step(1'b1, 1'b0, 1'b0, "gaps");
        step(1'b0, 1'b0, 1'b0, "gaps_idle");
        step(1'b1, 1'b1, 1'b0, "gaps");
        step(1'b0, 1'b0, 1'b0, "gaps_idle");
        step(1'b1, 1'b1, 1'b1, "gaps");
        step(1'b0, 1'b1, 1'b0, "gaps_nohold");
        check_cnt(8'd1, 1'b0, "gaps_count");
    endtask

    task automatic test_cfg_err();
        load(16'h000B, 5'd0, 1'b1);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_len0: cfg_err=%b expected 1", err); end
        stream(16'b1011, 16'b0000, 4, "err_disabled");
        load(16'h000B, 5'd4, 1'b1);
        load(16'h000B, 5'd17, 1'b1);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_len17: cfg_err=%b expected 1", err); end
        // Upper pattern bits are set so that only the masked compare can match.
        load(16'hFFFD, 5'd3, 1'b1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: cfg_err=%b expected 0", err); end
        stream(16'b10101, 16'b00101, 5, "len3");
        check_cnt(8'd2, 1'b0, "len3_count");
    endtask

    task automatic test_len1();
        load(16'h0001, 5'd1, 1'b0);
        stream(16'b1011, 16'b1011, 4, "len1");
        check_cnt(8'd3, 1'b0, "len1_count");
    endtask

    task automatic test_saturation();
        load(16'h000B, 5'd4, 1'b1);
        stream(16'b1011011, 16'b0001001, 7, "sat");
        checks++;
        if (count2 !== 2'd2 || sat2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_pre: count2=%0d sat2=%b expected 2 0", count2, sat2);
        end
        stream(16'b011011011, 16'b001001001, 9, "sat");
        checks++;
        if (count2 !== 2'd3 || sat2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: count2=%0d sat2=%b expected 3 1", count2, sat2);
        end
        check_cnt(8'd5, 1'b0, "sat_wide_count");
        load(16'h000B, 5'd4, 1'b1);
        checks++;
        if (count2 !== 2'd0 || sat2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: count2=%0d sat2=%b expected 0 0", count2, sat2);
        end
    endtask

    task automatic test_reset_mid();
        stream(16'b101101, 16'b000100, 6, "mid");
        #2 rst = 1'b0;
        #1;
        checks++;
        if (found !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: found=%b count=%0d expected 0 0", found, count);
        end
        @(negedge clk);
        rst = 1'b1;
        stream(16'b1011, 16'b0001, 4, "after_reset");
        check_cnt(8'd1, 1'b0, "after_reset_count");
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_cfg_err();
        test_len1();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
